corr_pkt_fifo: RTL and testbench

CORR_PKT_FIFO -- requirements
Module: corr_pkt_fifo

---
 rtl/corr_pkt_fifo_pkg.sv | 13 +
 rtl/corr_pkt_fifo_byte_fifo.sv | 73 +++++++
 rtl/corr_pkt_fifo.sv | 114 +++++++++++
 tb/tb_corr_pkt_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkt_fifo_pkg.sv
// Shared types and defaults for the correlator packet FIFO: serializer
// state encoding and the default packet/storage sizes.
package corrPkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int PKT_BYTES_DEF     = 4;
    localparam int PKTFIFO_DEPTH_DEF = 10;

endpackage

// File: rtl/corr_pkt_fifo_byte_fifo.sv
// Byte-wide circular FIFO with show-ahead read, occupancy count, flush and
// clock-gate hold. Pointers wrap at DEPTH-1, so any depth up to 255 works.
module byte_fifo #(
    parameter int DEPTH = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cg,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [7:0] o_data,
    output logic [7:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [0:DEPTH-1];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [7:0]    count_q, count_d;
    logic          do_push, do_pop;

    // A pop frees the head slot in the same cycle, so a full FIFO may push then.
    always_comb begin
        do_pop  = i_pop && (count_q != 8'd0);
        do_push = i_push && ((count_q != 8'(DEPTH)) || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 8'd1;
                2'b01:   count_d = count_q - 8'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (i_cg) begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; the count alone defines validity.
    always_ff @(posedge i_clk) begin
        if (i_cg && !i_flush && do_push) begin
            mem_q[wptr_q] <= i_push_data;
        end
    end

    assign o_data  = mem_q[rptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/corr_pkt_fifo.sv
// Correlator result packet FIFO: whole packets are accepted only when they fit,
// then serialized byte 0 first into byte_fifo. Optional drop counter: CORR_PKT_FIFO_DROPCOUNT_EN.
module corr_pkt_fifo
    import corrPkg::*;
#(
    parameter int PKT_BYTES     = PKT_BYTES_DEF,
    parameter int PKTFIFO_DEPTH = PKTFIFO_DEPTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cg,
    input  logic [8*PKT_BYTES-1:0] i_pkt_data,
    input  logic                   i_pkt_valid,
    input  logic                   i_flush,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic                   o_empty,
    output logic [7:0]             o_nEntries,
    output logic [7:0]             o_dropCount,
    output state_e                 o_state
);

    // Offer/consume semantics: i_pkt_valid is a one-cycle offer with no ready;
    // it is either taken whole or dropped. i_pop consumes o_data when !o_empty.

    state_e                 state_q;
    logic [8*PKT_BYTES-1:0] shreg_q;
    logic [4:0]             bidx_q;
    logic [8:0]             space;
    logic                   space_ok;
    logic                   accept;
    logic                   push;
    logic [7:0]             count;

    assign space    = 9'(PKTFIFO_DEPTH) - {1'b0, count};
    assign space_ok = (space >= 9'(PKT_BYTES));
    assign accept   = i_cg && !i_flush && i_pkt_valid && (state_q == IDLE) && space_ok;
    assign push     = (state_q == SHIFT) && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bidx_q  <= '0;
        end else if (i_cg) begin
            if (i_flush) begin
                state_q <= IDLE;
                bidx_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            shreg_q <= i_pkt_data;
                            bidx_q  <= '0;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        shreg_q <= shreg_q >> 8;
                        if (bidx_q == 5'(PKT_BYTES - 1)) begin
                            state_q <= IDLE;
                            bidx_q  <= '0;
                        end else begin
                            bidx_q <= bidx_q + 5'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    byte_fifo #(
        .DEPTH(PKTFIFO_DEPTH)
    ) u_byte_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cg        (i_cg),
        .i_push      (push),
        .i_push_data (shreg_q[7:0]),
        .i_pop       (i_pop),
        .i_flush     (i_flush),
        .o_data      (o_data),
        .o_count     (count)
    );

`ifdef CORR_PKT_FIFO_DROPCOUNT_EN
    logic       drop_evt;
    logic [7:0] drop_q;

    assign drop_evt = i_cg && !i_flush && i_pkt_valid && !accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_q <= '0;
        end else if (i_cg) begin
            if (i_flush) begin
                drop_q <= '0;
            end else if (drop_evt && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign o_dropCount = drop_q;
`else
    assign o_dropCount = 8'd0;
`endif

    assign o_nEntries = count;
    assign o_empty    = (count == 8'd0);
    assign o_state    = state_q;

endmodule

// File: tb/tb_corr_pkt_fifo.sv
// Directed bench for corr_pkt_fifo (PKT_BYTES=4, DEPTH=10) with a byte
// scoreboard; drop-count expectations follow CORR_PKT_FIFO_DROPCOUNT_EN.
module tb_corr_pkt_fifo;
    import corrPkg::*;

    localparam int PB    = 4;
    localparam int DEPTH = 10;
`ifdef CORR_PKT_FIFO_DROPCOUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_cg;
    logic [8*PB-1:0] i_pkt_data;
    logic            i_pkt_valid;
    logic            i_flush;
    logic            i_pop;
    logic [7:0]      o_data;
    logic            o_empty;
    logic [7:0]      o_nEntries;
    logic [7:0]      o_dropCount;
    state_e          o_state;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_drop = 0;

    always #5 i_clk = ~i_clk;

    corr_pkt_fifo #(
        .PKT_BYTES     (PB),
        .PKTFIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cg        (i_cg),
        .i_pkt_data  (i_pkt_data),
        .i_pkt_valid (i_pkt_valid),
        .i_flush     (i_flush),
        .i_pop       (i_pop),
        .o_data      (o_data),
        .o_empty     (o_empty),
        .o_nEntries  (o_nEntries),
        .o_dropCount (o_dropCount),
        .o_state     (o_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic note_drop();
        if (DROP_EN && exp_drop != 255) exp_drop++;
    endtask

    task automatic queue_pkt(input logic [8*PB-1:0] d);
        for (int b = 0; b < PB; b++) exp_q.push_back(d[8*b +: 8]);
    endtask

    // Offer a packet expected to be accepted and wait until it is fully stored.
    task automatic send_pkt(input logic [8*PB-1:0] d);
        i_pkt_data  = d;
        i_pkt_valid = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        queue_pkt(d);
        repeat (PB) step();
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_underflow observed=pop expected=no_data", tag);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check({tag, "_empty"}, {31'd0, o_empty}, 32'd0);
        check(tag, {24'd0, o_data}, {24'd0, e});
        i_pop = 1'b1;
        step();
        i_pop = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            pop_one(tag);
            guard++;
        end
        check({tag, "_drained_empty"}, {31'd0, o_empty}, 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_cg = 1'b1; i_pkt_data = '0;
        i_pkt_valid = 1'b0; i_flush = 1'b0; i_pop = 1'b0;
        #1;
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_count", {24'd0, o_nEntries}, 32'd0);
        check("rst_drop", {24'd0, o_dropCount}, 32'd0);
        check("rst_state", {31'd0, o_state}, {31'd0, IDLE});
        repeat (3) step();
        i_rst_n = 1'b1;
        step();

        // Basic accept: count ramps one byte per cycle after the accept edge.
        i_pkt_data = 32'h44332211; i_pkt_valid = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        queue_pkt(32'h44332211);
        check("acc_state", {31'd0, o_state}, {31'd0, SHIFT});
        for (int n = 1; n <= PB; n++) begin
            step();
            check($sformatf("acc_count%0d", n), {24'd0, o_nEntries}, n);
        end
        check("acc_idle", {31'd0, o_state}, {31'd0, IDLE});
        drain("acc_pop");

        i_pop = 1'b1;
        step();
        i_pop = 1'b0;
        check("emptypop_count", {24'd0, o_nEntries}, 32'd0);

        // Full drop, exact-fit acceptance, drop saturation, then flush.
        send_pkt(32'hA4A3A2A1);
        send_pkt(32'hB4B3B2B1);
        check("full8_count", {24'd0, o_nEntries}, 32'd8);
        i_pkt_data = 32'hDEADBEEF; i_pkt_valid = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        note_drop();
        step();
        check("full_drop_count", {24'd0, o_nEntries}, 32'd8);
        check("full_drop_drop", {24'd0, o_dropCount}, exp_drop);
        pop_one("full_pop");
        pop_one("full_pop");
        send_pkt(32'hC4C3C2C1);
        check("fit_count10", {24'd0, o_nEntries}, 32'd10);
        i_pkt_data = 32'h55555555; i_pkt_valid = 1'b1;
        for (int n = 0; n < 260; n++) begin
            step();
            note_drop();
        end
        i_pkt_valid = 1'b0;
        check("sat_drop", {24'd0, o_dropCount}, exp_drop);
        check("sat_count", {24'd0, o_nEntries}, 32'd10);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        check("flush_count", {24'd0, o_nEntries}, 32'd0);
        check("flush_drop", {24'd0, o_dropCount}, exp_drop);

        // Busy drop: second offer while serializing.
        i_pkt_data = 32'h14131211; i_pkt_valid = 1'b1;
        step();
        queue_pkt(32'h14131211);
        i_pkt_data = 32'h99999999;
        step();
        note_drop();
        i_pkt_valid = 1'b0;
        repeat (PB) step();
        check("busy_count", {24'd0, o_nEntries}, 32'd4);
        check("busy_drop", {24'd0, o_dropCount}, exp_drop);
        drain("busy_pop");

        // Flush mid-SHIFT with a simultaneous offer.
        i_pkt_data = 32'h24232221; i_pkt_valid = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        step();
        step();
        check("mid_count2", {24'd0, o_nEntries}, 32'd2);
        i_flush = 1'b1; i_pkt_valid = 1'b1; i_pkt_data = 32'h77777777;
        step();
        i_flush = 1'b0; i_pkt_valid = 1'b0;
        exp_drop = 0;
        check("mflush_count", {24'd0, o_nEntries}, 32'd0);
        check("mflush_state", {31'd0, o_state}, {31'd0, IDLE});
        check("mflush_drop", {24'd0, o_dropCount}, exp_drop);
        step();
        check("mflush_stays0", {24'd0, o_nEntries}, 32'd0);
        send_pkt(32'h34333231);
        check("mflush_next4", {24'd0, o_nEntries}, 32'd4);
        drain("mflush_pop");

        // Back-to-back packets with continuous pop: pointers wrap many times.
        for (int cyc = 0; cyc < 30 * (PB + 1); cyc++) begin
            logic [8*PB-1:0] d;
            d = $urandom;
            if (cyc % (PB + 1) == 0) begin
                i_pkt_data  = d;
                i_pkt_valid = 1'b1;
                queue_pkt(d);
            end else begin
                i_pkt_valid = 1'b0;
            end
            i_pop = !o_empty;
            if (!o_empty) begin
                logic [7:0] e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                check("stream_byte", {24'd0, o_data}, {24'd0, e});
            end
            step();
        end
        i_pkt_valid = 1'b0;
        i_pop = 1'b0;
        drain("stream_tail");
        check("stream_drop", {24'd0, o_dropCount}, exp_drop);

        // Asynchronous reset mid-SHIFT, checked without a clock edge.
        i_pkt_data = 32'h64636261; i_pkt_valid = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        step();
        check("ar_count1", {24'd0, o_nEntries}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_drop = 0;
        check("ar_empty", {31'd0, o_empty}, 32'd1);
        check("ar_count", {24'd0, o_nEntries}, 32'd0);
        check("ar_state", {31'd0, o_state}, {31'd0, IDLE});
        step();
        step();
        i_rst_n = 1'b1;
        repeat (PB) step();
        check("ar_no_residual", {31'd0, o_empty}, 32'd1);
        i_pop = 1'b1;
        step();
        i_pop = 1'b0;
        check("ar_emptypop_count", {24'd0, o_nEntries}, 32'd0);
        check("ar_emptypop_empty", {31'd0, o_empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
